exe_skid_buffer: RTL and testbench
==================================

EXE_SKID_BUFFER -- requirements
Module: exe_skid_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  pipeline clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  discard all buffered entries (branch taken); synchronous.
REQ-005 in_valid  input  1  ID stage presents an entry.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 id_bundle_in  input  147  packed ID/EX fields (layout REQ-010).
REQ-008 out_valid, out_ready  output, input  1 each  EXE-side handshake.
REQ-009 exe_bundle_out  output  147  head entry, same layout; occupancy  output  2  entry count 0..2.
REQ-010 Layout SHALL be:
- [146:115] pc; [114] wb_en; [113] mem_r_en; [112] mem_w_en; [111] b; [110] s
- [109:78] val_rn; [77:46] val_rm; [45:42] dest; [41:38] exe_cmd
- [37:26] shift_operand; [25:2] signed_imm_24; [1] imm; [0] c

Function
REQ-011 Two-entry FIFO (head, skid); states EMPTY, ONE, FULL; occupancy SHALL equal 0/1/2 respectively.
REQ-012 accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-013 in_ready SHALL be 1 iff state != FULL and rst = 0; it SHALL be a function of registered state only (no combinational path from out_ready).
REQ-014 out_valid SHALL be 1 iff state != EMPTY; exe_bundle_out SHALL be the head entry.
REQ-015 EMPTY: accept -> ONE, entry becomes head.
REQ-016 ONE: accept & !pop -> FULL (entry to skid); pop & !accept -> EMPTY; accept & pop -> ONE with new entry as head; neither -> hold.
REQ-017 FULL: pop -> ONE, skid entry moves to head; no accept is possible.
REQ-018 Latency SHALL be one cycle: an entry accepted at edge N into EMPTY appears with out_valid = 1 after edge N.
REQ-019 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush/rst.
REQ-020 Head and skid contents SHALL not change while held (out_valid & !out_ready).
REQ-021 flush SHALL force EMPTY at the next edge, discarding head, skid and any same-cycle accept; a same-cycle pop SHALL still count as consumed.
REQ-022 rst SHALL take priority over flush; flush over accept/pop.
REQ-023 When out_valid = 0, bits [114:110] of exe_bundle_out SHALL be 0 (bubble = NOP); other bits are don't-care.

Reset
REQ-024 On rst at a clock edge: state EMPTY, occupancy 0, out_valid 0, head and skid registers cleared to 0, exe_bundle_out all 0.
REQ-025 in_ready SHALL be 0 in every cycle rst is high; entries presented then SHALL be ignored.
REQ-026 Reset mid-operation SHALL discard all entries exactly as flush does.

Configuration
REQ-027 Macro EXE_SKID_STALL_CNT_EN: when defined, a 16-bit output stall_cycles SHALL exist, counting cycles with out_valid & !out_ready, saturating at 16'hFFFF, cleared by rst only (not flush).
REQ-028 Without EXE_SKID_STALL_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 rst 1 cycle, then in_valid with pc=0x10, out_ready=1 -> next cycle out_valid=1, exe_bundle_out[146:115]=0x10, occupancy=1.
REQ-030 out_ready=0, push pc=0x20 then 0x24 -> occupancy=2, in_ready=0; third push (0x28) ignored; raise out_ready -> outputs 0x20 then 0x24, never 0x28.
REQ-031 occupancy=1, simultaneous accept (0x30) and pop -> occupancy stays 1, head pc=0x30 next cycle.
REQ-032 occupancy=2, flush together with in_valid (0x40) -> next cycle occupancy=0, out_valid=0, bits [114:110]=0; 0x40 never output.
REQ-033 Empty buffer -> exe_bundle_out[114:110]=0 every cycle; in_ready=0 throughout a rst pulse mid-stream.
REQ-034 With EXE_SKID_STALL_CNT_EN, hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5; flush leaves it 5; rst clears to 0.

Source files
------------

// File: rtl/exe_skid_buffer_if.sv
// ID->EXE handshake bundle for exe_skid_buffer.
// master = upstream/downstream driver side, slave = the buffer itself.
interface exe_skid_buffer_if;
  logic         in_valid;
  logic         in_ready;
  logic [146:0] id_bundle_in;
  logic         out_valid;
  logic         out_ready;
  logic [146:0] exe_bundle_out;
  logic [1:0]   occupancy;

  modport master (
    output in_valid, id_bundle_in, out_ready,
    input  in_ready, out_valid, exe_bundle_out, occupancy
  );

  modport slave (
    input  in_valid, id_bundle_in, out_ready,
    output in_ready, out_valid, exe_bundle_out, occupancy
  );
endinterface

// File: rtl/exe_skid_buffer.sv
// Two-entry ID->EXE skid FIFO (head + skid) with flush and NOP bubbles.
// Optional stall counter enabled by defining EXE_SKID_STALL_CNT_EN.
module exe_skid_buffer (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  exe_skid_buffer_if.slave  bus
`ifdef EXE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [146:0] head_q, head_d;
  logic [146:0] skid_q, skid_d;
  logic         accept;
  logic         pop;

  // in_ready depends only on registered state and rst, never on out_ready
  assign bus.in_ready       = (state_q != FULL) && !rst;
  assign bus.out_valid      = (state_q != EMPTY);
  assign bus.exe_bundle_out = bus.out_valid ? head_q : '0;
  assign bus.occupancy      = 2'(state_q);

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = bus.id_bundle_in;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = FULL;
          skid_d  = bus.id_bundle_in;
        end else if (pop && !accept) begin
          state_d = EMPTY;
        end else if (accept && pop) begin
          head_d  = bus.id_bundle_in;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything including a same-cycle accept; a pop is simply consumed.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef EXE_SKID_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_exe_skid_buffer.sv
// Self-checking bench for exe_skid_buffer: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_exe_skid_buffer;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  exe_skid_buffer_if bus ();

`ifdef EXE_SKID_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] stall_m;
`endif

  exe_skid_buffer dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef EXE_SKID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  logic [146:0] q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [146:0] obs, input logic [146:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [146:0] mk(input logic [31:0] pc);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r[146:115] = pc;
    return r[146:0];
  endfunction

  // One clock: drive at posedge+1, check at negedge, update model at posedge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, input logic rs);
    logic [146:0] b;
    logic exp_ov;
    logic exp_ir;
    logic acc;
    logic pp;
    b = mk(pc);
    bus.in_valid     = v;
    bus.id_bundle_in = b;
    bus.out_ready    = rdy;
    flush            = fl;
    rst              = rs;
    #4;
    exp_ov = (q.size() != 0);
    exp_ir = (q.size() < 2) && !rs;
    chk("in_ready", 147'(bus.in_ready), 147'(exp_ir));
    chk("out_valid", 147'(bus.out_valid), 147'(exp_ov));
    chk("occupancy", 147'(bus.occupancy), 147'(q.size()));
    if (exp_ov) chk("head_bundle", bus.exe_bundle_out, q[0]);
    else        chk("nop_bits", 147'(bus.exe_bundle_out[114:110]), 147'(0));
`ifdef EXE_SKID_STALL_CNT_EN
    chk("stall_cycles", 147'(stall_cycles), 147'(stall_m));
`endif
    acc = v && exp_ir;
    pp  = exp_ov && rdy;
`ifdef EXE_SKID_STALL_CNT_EN
    if (rs) stall_m = 16'd0;
    else if (exp_ov && !rdy && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
`endif
    if (rs || fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.id_bundle_in = '0;
    @(posedge clk);
    #1;
    q.delete();
`ifdef EXE_SKID_STALL_CNT_EN
    stall_m = 16'd0;
`endif
    chk("rst_bundle_zero", bus.exe_bundle_out, 147'(0));
    chk("rst_occupancy", 147'(bus.occupancy), 147'(0));
    cycle(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);

    // Single entry, one-cycle latency
    cycle(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    chk("lat_pc_0x10", 147'(bus.exe_bundle_out[146:115]), 147'(32'h10));
    chk("lat_occ1", 147'(bus.occupancy), 147'(1));

    // Fill to two with backpressure; third push must be ignored
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
    chk("full_occ2", 147'(bus.occupancy), 147'(2));
    chk("full_in_ready0", 147'(bus.in_ready), 147'(0));
    cycle(1'b1, 32'h28, 1'b0, 1'b0, 1'b0);
    chk("held_pc_0x20", 147'(bus.exe_bundle_out[146:115]), 147'(32'h20));
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_pc_0x24", 147'(bus.exe_bundle_out[146:115]), 147'(32'h24));
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 147'(bus.occupancy), 147'(0));

    // Simultaneous accept and pop at occupancy 1
    cycle(1'b1, 32'h2c, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
    chk("swap_occ1", 147'(bus.occupancy), 147'(1));
    chk("swap_pc_0x30", 147'(bus.exe_bundle_out[146:115]), 147'(32'h30));

    // Flush at occupancy 2 together with an incoming entry
    cycle(1'b1, 32'h34, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    chk("flush_occ0", 147'(bus.occupancy), 147'(0));
    chk("flush_ov0", 147'(bus.out_valid), 147'(0));
    chk("flush_nop", 147'(bus.exe_bundle_out[114:110]), 147'(0));
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset pulse mid-stream
    cycle(1'b1, 32'h50, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h54, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h58, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h5c, 1'b1, 1'b0, 1'b1);
    chk("midrst_occ0", 147'(bus.occupancy), 147'(0));
    chk("midrst_bundle_zero", bus.exe_bundle_out, 147'(0));

`ifdef EXE_SKID_STALL_CNT_EN
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_5", 147'(stall_cycles), 147'(5));
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("stall_after_flush", 147'(stall_cycles), 147'(5));
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("stall_after_rst", 147'(stall_cycles), 147'(0));
`endif

    // Random traffic
    for (int unsigned i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
